// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/hazard controller for the hi/lo mult/div unit.
// It decodes the E-stage md op into unit strobes and tracks the unit's run
// latency locally, so stalls begin the cycle after a start. This covers the
// cycle before the unit raises busy. It also sequences the exception cancel
// (stop) and the eret hi/lo restore (ret).
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       op_valid_i,
  input  logic [2:0] op_code_i,
  input  logic       flush_i,
  input  logic       eret_i,
  input  logic       md_busy_i,
  output logic       md_start_o,
  output logic [1:0] md_mode_o,
  output logic       md_we_o,
  output logic       md_a1_o,
  output logic       md_stop_o,
  output logic       md_ret_o,
  output logic       stall_o,
  output logic       proto_err_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       ret_pend_q;
  logic       ret_fire_q;
  logic       busy_idle_q;
  logic       proto_err_q;
  logic       go;
  logic       is_idle;

  // Issue decode: an md op goes out only when not flushed and not held by a
  // running operation; mode and a1 follow the opcode directly.
  always_comb begin
    is_idle     = (state_q == IDLE);
    stall_o     = op_valid_i & ~is_idle & ~flush_i;
    go          = op_valid_i & ~flush_i & ~stall_o;
    md_start_o  = go & ~op_code_i[2];
    md_we_o     = go & op_code_i[2] & ~op_code_i[1];
    md_mode_o   = op_code_i[1:0];
    md_a1_o     = ~op_code_i[0];
    md_stop_o   = flush_i;
    md_ret_o    = ~flush_i & ((eret_i & is_idle) | ret_fire_q);
    proto_err_o = proto_err_q;
  end

  // Run/idle sequencer with latency countdown, deferred eret restore and the
  // sticky busy-while-idle protocol check.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ret_pend_q  <= 1'b0;
      ret_fire_q  <= 1'b0;
      busy_idle_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      ret_fire_q  <= 1'b0;
      busy_idle_q <= md_busy_i & is_idle;
      if (busy_idle_q & md_busy_i & is_idle) begin
        proto_err_q <= 1'b1;
      end
      if (flush_i) begin
        state_q    <= IDLE;
        cnt_q      <= 4'd0;
        ret_pend_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (md_start_o) begin
              state_q <= RUN;
              cnt_q   <= op_code_i[1] ? 4'(DIV_LAT) : 4'(MULT_LAT);
            end
          end
          RUN: begin
            if (cnt_q <= 4'd1) begin
              state_q    <= IDLE;
              cnt_q      <= 4'd0;
              ret_pend_q <= 1'b0;
              ret_fire_q <= ret_pend_q | eret_i;
            end else begin
              cnt_q      <= cnt_q - 4'd1;
              ret_pend_q <= ret_pend_q | eret_i;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed checks of issue, stall timing, flush, eret
// restore sequencing, async reset and the busy protocol flag.
module tb_md_issue_ctrl;

  logic       clk;
  logic       clr_n;
  logic       opValid;
  logic [2:0] opCode;
  logic       flush;
  logic       eret;
  logic       mdBusy;
  logic       mdStart;
  logic [1:0] mdMode;
  logic       mdWe;
  logic       mdA1;
  logic       mdStop;
  logic       mdRet;
  logic       stall;
  logic       protoErr;

  int testsRun;
  int testsFailed;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .op_valid_i (opValid),
    .op_code_i  (opCode),
    .flush_i    (flush),
    .eret_i     (eret),
    .md_busy_i  (mdBusy),
    .md_start_o (mdStart),
    .md_mode_o  (mdMode),
    .md_we_o    (mdWe),
    .md_a1_o    (mdA1),
    .md_stop_o  (mdStop),
    .md_ret_o   (mdRet),
    .stall_o    (stall),
    .proto_err_o(protoErr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs just after the edge, then wait to mid-cycle.
  task automatic applyStimulus(input logic v, input logic [2:0] c,
                               input logic f, input logic e, input logic b);
    @(posedge clk);
    #1;
    opValid = v;
    opCode  = c;
    flush   = f;
    eret    = e;
    mdBusy  = b;
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs,
                             input logic [3:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    clr_n   = 1'b0;
    opValid = 1'b0;
    opCode  = 3'b000;
    flush   = 1'b0;
    eret    = 1'b0;
    mdBusy  = 1'b0;

    #1;
    checkOutput("rst_stall", {3'b0, stall}, 4'd0);
    checkOutput("rst_start", {3'b0, mdStart}, 4'd0);
    checkOutput("rst_ret", {3'b0, mdRet}, 4'd0);
    checkOutput("rst_proto", {3'b0, protoErr}, 4'd0);
    #1;
    clr_n = 1'b1;

    // MULT at T0, MFLO waiting from T1: stalls T1..T5, issues T6
    applyStimulus(1'b1, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("mult_start", {3'b0, mdStart}, 4'd1);
    checkOutput("mult_stall", {3'b0, stall}, 4'd0);
    checkOutput("mult_mode", {2'b0, mdMode}, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, OP_MFLO, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("mflo_stall_T%0d", i), {3'b0, stall}, 4'd1);
      checkOutput($sformatf("mflo_nostart_T%0d", i), {3'b0, mdStart}, 4'd0);
    end
    applyStimulus(1'b1, OP_MFLO, 1'b0, 1'b0, 1'b0);
    checkOutput("mflo_issue_stall", {3'b0, stall}, 4'd0);
    checkOutput("mflo_issue_start", {3'b0, mdStart}, 4'd0);
    checkOutput("mflo_issue_we", {3'b0, mdWe}, 4'd0);
    checkOutput("mflo_a1", {3'b0, mdA1}, 4'd0);

    // MULT at T0, eret at T2: restore strobe exactly at T6
    applyStimulus(1'b1, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("ret_mult_start", {3'b0, mdStart}, 4'd1);
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("nonmd_nostall", {3'b0, stall}, 4'd0);
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b1, 1'b0);
    checkOutput("ret_T2", {3'b0, mdRet}, 4'd0);
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("ret_T%0d", i), {3'b0, mdRet}, 4'd0);
    end
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("ret_T6", {3'b0, mdRet}, 4'd1);
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("ret_T7", {3'b0, mdRet}, 4'd0);

    // DIVU at T0, MTHI waiting: stalls T1..T10, writes HI at T11
    applyStimulus(1'b1, OP_DIVU, 1'b0, 1'b0, 1'b0);
    checkOutput("divu_start", {3'b0, mdStart}, 4'd1);
    checkOutput("divu_mode", {2'b0, mdMode}, 4'd3);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, OP_MTHI, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("mthi_stall_T%0d", i), {3'b0, stall}, 4'd1);
      checkOutput($sformatf("mthi_nowe_T%0d", i), {3'b0, mdWe}, 4'd0);
    end
    applyStimulus(1'b1, OP_MTHI, 1'b0, 1'b0, 1'b0);
    checkOutput("mthi_T11_stall", {3'b0, stall}, 4'd0);
    checkOutput("mthi_T11_we", {3'b0, mdWe}, 4'd1);
    checkOutput("mthi_T11_a1", {3'b0, mdA1}, 4'd1);

    // DIV at T0, flush at T3: IDLE at T4 and a MULT issues without stall
    applyStimulus(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0);
    checkOutput("div_start", {3'b0, mdStart}, 4'd1);
    checkOutput("div_mode", {2'b0, mdMode}, 4'd2);
    applyStimulus(1'b0, OP_DIV, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_DIV, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_DIV, 1'b1, 1'b0, 1'b0);
    checkOutput("flush_stop", {3'b0, mdStop}, 4'd1);
    checkOutput("flush_stall", {3'b0, stall}, 4'd0);
    checkOutput("flush_start", {3'b0, mdStart}, 4'd0);
    applyStimulus(1'b1, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("postflush_start", {3'b0, mdStart}, 4'd1);
    checkOutput("postflush_stall", {3'b0, stall}, 4'd0);
    checkOutput("postflush_stop", {3'b0, mdStop}, 4'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b0);
    end

    // MTLO with flush is killed; MFHI in IDLE reads HI with no stall
    applyStimulus(1'b1, OP_MTLO, 1'b1, 1'b0, 1'b0);
    checkOutput("mtlo_flush_we", {3'b0, mdWe}, 4'd0);
    checkOutput("mtlo_flush_stop", {3'b0, mdStop}, 4'd1);
    applyStimulus(1'b1, OP_MTLO, 1'b0, 1'b0, 1'b0);
    checkOutput("mtlo_we", {3'b0, mdWe}, 4'd1);
    checkOutput("mtlo_a1", {3'b0, mdA1}, 4'd0);
    applyStimulus(1'b1, OP_MFHI, 1'b0, 1'b0, 1'b0);
    checkOutput("mfhi_a1", {3'b0, mdA1}, 4'd1);
    checkOutput("mfhi_stall", {3'b0, stall}, 4'd0);
    checkOutput("mfhi_we", {3'b0, mdWe}, 4'd0);

    // eret in IDLE restores at once; flush overrides it
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b1, 1'b0);
    checkOutput("eret_idle_ret", {3'b0, mdRet}, 4'd1);
    applyStimulus(1'b0, OP_MULT, 1'b1, 1'b1, 1'b0);
    checkOutput("eret_flush_ret", {3'b0, mdRet}, 4'd0);
    applyStimulus(1'b1, OP_MTHI, 1'b0, 1'b1, 1'b0);
    checkOutput("eret_mt_ret", {3'b0, mdRet}, 4'd1);
    checkOutput("eret_mt_we", {3'b0, mdWe}, 4'd1);

    // Async reset in the middle of a MULT run drops the stall at once
    applyStimulus(1'b1, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("rmid_start", {3'b0, mdStart}, 4'd1);
    applyStimulus(1'b1, OP_MFLO, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_MFLO, 1'b0, 1'b0, 1'b0);
    checkOutput("rmid_stall_before", {3'b0, stall}, 4'd1);
    #1;
    clr_n = 1'b0;
    #1;
    checkOutput("rmid_stall_after", {3'b0, stall}, 4'd0);
    #1;
    clr_n = 1'b1;

    // busy held two cycles while IDLE sets the sticky protocol flag
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b1);
    checkOutput("proto_c1", {3'b0, protoErr}, 4'd0);
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b1);
    checkOutput("proto_c2", {3'b0, protoErr}, 4'd0);
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("proto_set", {3'b0, protoErr}, 4'd1);
    applyStimulus(1'b0, OP_MULT, 1'b0, 1'b0, 1'b0);
    checkOutput("proto_sticky", {3'b0, protoErr}, 4'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
